// File: rtl/fdma_axi_pkg.sv
// Shared AXI constants and a constant-evaluation log2 helper for the FDMA write master.
package fdma_axi_pkg;

  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam int unsigned AXI_4K_BOUNDARY = 4096;

  // Ceiling log2; used on parameters only, so it folds at elaboration.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fdma_burst_calc.sv
// Burst length for the next AXI burst: min(remaining, max burst length, beats left in the 4 KB page).
module fdma_burst_calc
  import fdma_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH    = 128,
  parameter int unsigned AXI_MAX_BURST_LEN = 256
) (
  input  logic [11:0] i_addr_lo,
  input  logic [15:0] i_remaining,
  output logic [8:0]  o_len
);

  localparam int unsigned BPB   = AXI_DATA_WIDTH / 8;
  localparam int unsigned SHIFT = clog2(BPB);
  localparam logic [12:0] MAX13 = 13'(AXI_MAX_BURST_LEN);

  logic [12:0] w_bytes_to_4k;
  logic [12:0] w_beats_to_4k;
  logic [12:0] w_cap;

  // Address is beat-aligned, so the page remainder divides exactly into beats.
  assign w_bytes_to_4k = 13'(AXI_4K_BOUNDARY) - {1'b0, i_addr_lo};
  assign w_beats_to_4k = w_bytes_to_4k >> SHIFT;

  // Clamp the page remainder to the AXI burst limit, then to the beats still owed.
  always_comb begin
    w_cap = (w_beats_to_4k < MAX13) ? w_beats_to_4k : MAX13;
    if ({3'b000, w_cap} > i_remaining) begin
      o_len = i_remaining[8:0];
    end else begin
      o_len = w_cap[8:0];
    end
  end

endmodule

// File: rtl/fdma_axi_wmaster.sv
// FDMA write master: splits one FDMA write request into AXI4 INCR bursts, one burst in flight.
module fdma_axi_wmaster
  import fdma_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH    = 128,
  parameter int unsigned AXI_ADDR_WIDTH    = 32,
  parameter int unsigned AXI_MAX_BURST_LEN = 256,
  parameter logic [3:0]  AXI_ID            = 4'd0
) (
  input  logic                        I_ui_clk,
  input  logic                        I_ui_rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   I_fdma_waddr,
  input  logic                        I_fdma_wareq,
  input  logic [15:0]                 I_fdma_wsize,
  output logic                        O_fdma_wbusy,
  output logic                        O_fdma_wvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   I_fdma_wdata,
  output logic                        O_fdma_werr,
  output logic [3:0]                  M_AXI_AWID,
  output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                  M_AXI_AWLEN,
  output logic [2:0]                  M_AXI_AWSIZE,
  output logic [1:0]                  M_AXI_AWBURST,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WLAST,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY
);

  localparam int unsigned BPB   = AXI_DATA_WIDTH / 8;
  localparam int unsigned SHIFT = clog2(BPB);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~(AXI_ADDR_WIDTH'(BPB - 1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  logic [1:0]                r_state;
  logic                      r_busy;
  logic                      r_werr;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [15:0]               r_remaining;
  logic [7:0]                r_awlen;
  logic [7:0]                r_beat;

  logic [AXI_ADDR_WIDTH-1:0] w_addr_align;
  logic [8:0]                w_cur_len;
  logic [AXI_ADDR_WIDTH-1:0] w_next_addr;
  logic [15:0]               w_next_rem;
  logic [11:0]               w_calc_addr;
  logic [15:0]               w_calc_rem;
  logic [8:0]                w_calc_len;
  logic [7:0]                w_awlen_nxt;
  logic                      w_in_w;
  logic                      w_wlast;

  assign w_addr_align = I_fdma_waddr & ADDR_MASK;
  assign w_cur_len    = {1'b0, r_awlen} + 9'd1;
  assign w_next_addr  = r_addr + (AXI_ADDR_WIDTH'(w_cur_len) << SHIFT);
  assign w_next_rem   = r_remaining - {7'd0, w_cur_len};

  // The length calculator serves both a fresh request (IDLE) and the follow-on burst (B).
  assign w_calc_addr  = (r_state == S_IDLE) ? w_addr_align[11:0] : w_next_addr[11:0];
  assign w_calc_rem   = (r_state == S_IDLE) ? I_fdma_wsize : w_next_rem;
  assign w_awlen_nxt  = 8'(w_calc_len - 9'd1);

  fdma_burst_calc #(
    .AXI_DATA_WIDTH   (AXI_DATA_WIDTH),
    .AXI_MAX_BURST_LEN(AXI_MAX_BURST_LEN)
  ) u_burst_calc (
    .i_addr_lo  (w_calc_addr),
    .i_remaining(w_calc_rem),
    .o_len      (w_calc_len)
  );

  assign w_in_w  = (r_state == S_W);
  assign w_wlast = w_in_w & (r_beat == r_awlen);

  assign O_fdma_wbusy  = r_busy;
  assign O_fdma_werr   = r_werr;
  assign O_fdma_wvalid = w_in_w & M_AXI_WREADY;
  assign M_AXI_AWID    = AXI_ID;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWSIZE  = 3'(SHIFT);
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWVALID = (r_state == S_AW);
  assign M_AXI_WDATA   = I_fdma_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = w_wlast;
  assign M_AXI_WVALID  = w_in_w;
  assign M_AXI_BREADY  = (r_state == S_B);

  // Request FSM with burst address/remaining bookkeeping and the in-burst beat counter.
  always_ff @(posedge I_ui_clk) begin
    if (I_ui_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_werr      <= 1'b0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_awlen     <= '0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A busy flag still set in IDLE is the one-cycle echo of a zero-size request.
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (I_fdma_wareq) begin
            r_busy <= 1'b1;
            if (I_fdma_wsize != 16'd0) begin
              r_addr      <= w_addr_align;
              r_remaining <= I_fdma_wsize;
              r_awlen     <= w_awlen_nxt;
              r_state     <= S_AW;
            end
          end
        end
        S_AW: begin
          if (M_AXI_AWREADY) begin
            r_beat  <= '0;
            r_state <= S_W;
          end
        end
        S_W: begin
          if (M_AXI_WREADY) begin
            if (w_wlast) begin
              r_state <= S_B;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        default: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != AXI_RESP_OKAY) begin
              r_werr <= 1'b1;
            end
            r_addr      <= w_next_addr;
            r_remaining <= w_next_rem;
            if (w_next_rem == 16'd0) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_awlen <= w_awlen_nxt;
              r_state <= S_AW;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdma_axi_wmaster.sv
// Self-checking bench for fdma_axi_wmaster: table of requests, hand-written corner sequences,
// and randomized requests checked against a burst-splitting reference model.
module tb_fdma_axi_wmaster;

  logic         I_ui_clk = 1'b0;
  logic         I_ui_rst = 1'b1;
  logic [31:0]  I_fdma_waddr = '0;
  logic         I_fdma_wareq = 1'b0;
  logic [15:0]  I_fdma_wsize = '0;
  logic         O_fdma_wbusy;
  logic         O_fdma_wvalid;
  logic [127:0] I_fdma_wdata;
  logic         O_fdma_werr;
  logic [3:0]   M_AXI_AWID;
  logic [31:0]  M_AXI_AWADDR;
  logic [7:0]   M_AXI_AWLEN;
  logic [2:0]   M_AXI_AWSIZE;
  logic [1:0]   M_AXI_AWBURST;
  logic         M_AXI_AWVALID;
  logic         M_AXI_AWREADY = 1'b0;
  logic [127:0] M_AXI_WDATA;
  logic [15:0]  M_AXI_WSTRB;
  logic         M_AXI_WLAST;
  logic         M_AXI_WVALID;
  logic         M_AXI_WREADY = 1'b0;
  logic [1:0]   M_AXI_BRESP = 2'b00;
  logic         M_AXI_BVALID = 1'b0;
  logic         M_AXI_BREADY;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] fifo_mem [0:1023];
  logic [9:0]   rd_ptr = '0;
  assign I_fdma_wdata = fifo_mem[rd_ptr];

  logic [31:0] exp_addr_q[$];
  int          exp_len_q[$];
  logic        exp_werr = 1'b0;

  fdma_axi_wmaster dut (
    .I_ui_clk     (I_ui_clk),
    .I_ui_rst     (I_ui_rst),
    .I_fdma_waddr (I_fdma_waddr),
    .I_fdma_wareq (I_fdma_wareq),
    .I_fdma_wsize (I_fdma_wsize),
    .O_fdma_wbusy (O_fdma_wbusy),
    .O_fdma_wvalid(O_fdma_wvalid),
    .I_fdma_wdata (I_fdma_wdata),
    .O_fdma_werr  (O_fdma_werr),
    .M_AXI_AWID   (M_AXI_AWID),
    .M_AXI_AWADDR (M_AXI_AWADDR),
    .M_AXI_AWLEN  (M_AXI_AWLEN),
    .M_AXI_AWSIZE (M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA  (M_AXI_WDATA),
    .M_AXI_WSTRB  (M_AXI_WSTRB),
    .M_AXI_WLAST  (M_AXI_WLAST),
    .M_AXI_WVALID (M_AXI_WVALID),
    .M_AXI_WREADY (M_AXI_WREADY),
    .M_AXI_BRESP  (M_AXI_BRESP),
    .M_AXI_BVALID (M_AXI_BVALID),
    .M_AXI_BREADY (M_AXI_BREADY)
  );

  always #5 I_ui_clk = ~I_ui_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected burst list from the splitting rules: 16-byte beats, 256-beat cap, 4 KB pages.
  task automatic build_model(input logic [31:0] addr, input int unsigned n);
    logic [31:0] cur;
    int unsigned rem, room, len;
    exp_addr_q.delete();
    exp_len_q.delete();
    cur = addr & 32'hFFFF_FFF0;
    rem = n;
    while (rem > 0) begin
      room = (4096 - (cur % 4096)) / 16;
      len  = rem;
      if (len > 256)  len = 256;
      if (len > room) len = room;
      exp_addr_q.push_back(cur);
      exp_len_q.push_back(int'(len));
      cur = cur + 32'(len * 16);
      rem = rem - len;
    end
  endtask

  // Issue one request and act as the AXI slave. mode: 0 WREADY=1, 1 toggle 1/0, 2 random.
  // abort_after>0 raises reset in the cycle of that pop and returns without end checks.
  task automatic run_req(input logic [31:0] addr, input int unsigned n, input int mode,
                         input int awdelay, input int err_burst, input int abort_after,
                         output int n_aw, output logic [7:0] last_len);
    int aw_idx = 0, w_beat = 0, pops = 0, b_idx = 0, awwait = 0, bwait = 0, cyc = 0;
    int err_aw = 0, err_w = 0, b_last_cyc = -1, busy_drop = -1;
    logic [7:0] cur_len = '0;
    bit done = 0, tog = 1, pop_pending = 0, aborted = 0;
    for (int i = 0; i < int'(n); i++) fifo_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rd_ptr = '0;
    last_len = '0;
    @(negedge I_ui_clk);
    I_fdma_waddr = addr;
    I_fdma_wsize = 16'(n);
    I_fdma_wareq = 1'b1;
    @(negedge I_ui_clk);
    I_fdma_wareq = 1'b0;
    check("busy_after_req", 64'(O_fdma_wbusy), 64'd1);
    check("awvalid_after_req", 64'(M_AXI_AWVALID), 64'd1);
    while (!done && !aborted && cyc < 20000) begin
      if (M_AXI_AWVALID) begin
        M_AXI_AWREADY = (awwait >= awdelay);
        awwait++;
      end else begin
        M_AXI_AWREADY = 1'b0;
        awwait = 0;
      end
      case (mode)
        0:       M_AXI_WREADY = 1'b1;
        1:       begin M_AXI_WREADY = tog; tog = !tog; end
        default: M_AXI_WREADY = 1'($urandom_range(0, 1));
      endcase
      if (M_AXI_BREADY) begin
        M_AXI_BVALID = (bwait >= 2);
        bwait++;
      end else begin
        M_AXI_BVALID = 1'b0;
        bwait = 0;
      end
      M_AXI_BRESP = (b_idx == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (M_AXI_AWVALID && M_AXI_WVALID) err_aw++;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        if (aw_idx >= exp_addr_q.size()) err_aw++;
        else if (M_AXI_AWADDR !== exp_addr_q[aw_idx] ||
                 M_AXI_AWLEN !== 8'(exp_len_q[aw_idx] - 1)) err_aw++;
        cur_len  = M_AXI_AWLEN;
        last_len = M_AXI_AWLEN;
        aw_idx++;
        w_beat = 0;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (!O_fdma_wvalid || M_AXI_WDATA !== fifo_mem[rd_ptr] ||
            M_AXI_WLAST !== (w_beat == int'(cur_len)) || M_AXI_WSTRB !== 16'hFFFF) err_w++;
        pops++;
        w_beat++;
        pop_pending = 1;
      end else if (O_fdma_wvalid) begin
        err_w++;
      end
      if (M_AXI_BREADY && M_AXI_BVALID) begin
        b_idx++;
        b_last_cyc = cyc;
      end
      if (abort_after > 0 && pops >= abort_after) begin
        I_ui_rst = 1'b1;
        aborted  = 1;
      end
      @(posedge I_ui_clk);
      if (pop_pending) begin
        rd_ptr = rd_ptr + 10'd1;
        pop_pending = 0;
      end
      @(negedge I_ui_clk);
      cyc++;
      if (!O_fdma_wbusy) begin
        done = 1;
        busy_drop = cyc;
      end
    end
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_BVALID  = 1'b0;
    n_aw = aw_idx;
    if (!aborted) begin
      check("completed_in_budget", 64'(done), 64'd1);
      check("aw_count", 64'(aw_idx), 64'(exp_addr_q.size()));
      check("aw_fields_errors", 64'(err_aw), 64'd0);
      check("w_beat_errors", 64'(err_w), 64'd0);
      check("pop_count", 64'(pops), 64'(n));
      check("b_count", 64'(b_idx), 64'(exp_addr_q.size()));
      check("busy_drop_cycle", 64'(busy_drop), 64'(b_last_cyc + 1));
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    int          wsize;
    int          mode;
    int          awdelay;
    int          err_burst;
    int          exp_bursts;
    logic [7:0]  exp_last_len;
    logic        exp_werr;
  } vec_t;

  vec_t vecs[9];

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},    64'(O_fdma_wbusy),  64'd0);
    check({tag, "_wvalid"},  64'(O_fdma_wvalid), 64'd0);
    check({tag, "_werr"},    64'(O_fdma_werr),   64'd0);
    check({tag, "_awvalid"}, 64'(M_AXI_AWVALID), 64'd0);
    check({tag, "_wvalid_axi"}, 64'(M_AXI_WVALID), 64'd0);
    check({tag, "_wlast"},   64'(M_AXI_WLAST),   64'd0);
    check({tag, "_bready"},  64'(M_AXI_BREADY),  64'd0);
    check({tag, "_awaddr"},  64'(M_AXI_AWADDR),  64'd0);
    check({tag, "_awlen"},   64'(M_AXI_AWLEN),   64'd0);
  endtask

  initial begin
    int n_aw;
    logic [7:0] last_len;
    int busy_cycles, aw_seen;

    //           addr          size mode awd err bursts last  werr
    vecs[0] = '{32'h0000_0000, 240, 0,   0,  -1, 1,     8'd239, 1'b0};
    vecs[1] = '{32'h0000_0000, 600, 0,   0,  -1, 3,     8'd87,  1'b0};
    vecs[2] = '{32'h0000_0F80, 20,  0,   0,  -1, 2,     8'd11,  1'b0};
    vecs[3] = '{32'h0000_0100, 16,  1,   5,  -1, 1,     8'd15,  1'b0};
    vecs[4] = '{32'h0000_3000, 600, 2,   1,  1,  3,     8'd87,  1'b1};
    vecs[5] = '{32'h0000_0010, 1,   0,   0,  -1, 1,     8'd0,   1'b1};
    vecs[6] = '{32'h0FFF_FFF7, 3,   2,   2,  -1, 2,     8'd1,   1'b1};
    vecs[7] = '{32'hFFFF_FFF0, 2,   0,   0,  -1, 2,     8'd0,   1'b1};
    vecs[8] = '{32'h0000_07A0, 300, 2,   3,  -1, 2,     8'd165, 1'b1};

    repeat (3) @(negedge I_ui_clk);
    check_reset_values("reset");
    check("awsize_const",  64'(M_AXI_AWSIZE),  64'd4);
    check("awburst_const", 64'(M_AXI_AWBURST), 64'd1);
    check("awid_const",    64'(M_AXI_AWID),    64'd0);
    I_ui_rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      build_model(vecs[i].addr, vecs[i].wsize);
      run_req(vecs[i].addr, vecs[i].wsize, vecs[i].mode, vecs[i].awdelay, vecs[i].err_burst,
              0, n_aw, last_len);
      check($sformatf("vec%0d_bursts", i), 64'(n_aw), 64'(vecs[i].exp_bursts));
      check($sformatf("vec%0d_last_awlen", i), 64'(last_len), 64'(vecs[i].exp_last_len));
      check($sformatf("vec%0d_werr", i), 64'(O_fdma_werr), 64'(vecs[i].exp_werr));
    end

    // Zero-size request: busy for one cycle, no AW.
    @(negedge I_ui_clk);
    I_fdma_waddr = 32'h0000_5000;
    I_fdma_wsize = 16'd0;
    I_fdma_wareq = 1'b1;
    busy_cycles = 0;
    aw_seen = 0;
    @(negedge I_ui_clk);
    I_fdma_wareq = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (O_fdma_wbusy) busy_cycles++;
      if (M_AXI_AWVALID) aw_seen++;
      @(negedge I_ui_clk);
    end
    check("zero_size_busy_cycles", 64'(busy_cycles), 64'd1);
    check("zero_size_no_aw", 64'(aw_seen), 64'd0);

    // Reset during beat 5 of a 240-beat burst, then a clean request.
    build_model(32'h0000_0000, 240);
    run_req(32'h0000_0000, 240, 0, 0, -1, 5, n_aw, last_len);
    @(negedge I_ui_clk);
    check_reset_values("mid_w_reset");
    I_ui_rst = 1'b0;
    exp_werr = 1'b0;
    build_model(32'h0000_2000, 240);
    run_req(32'h0000_2000, 240, 0, 0, -1, 0, n_aw, last_len);
    check("after_reset_last_awlen", 64'(last_len), 64'd239);
    check("after_reset_werr", 64'(O_fdma_werr), 64'd0);

    // Randomized requests against the model.
    for (int r = 0; r < 10; r++) begin
      logic [31:0] ra;
      int rs, rerr;
      ra   = $urandom;
      if (r % 2 == 0) ra[11:0] = 12'(4096 - 16 * $urandom_range(1, 40));
      rs   = $urandom_range(1, 700);
      rerr = int'($urandom_range(0, 3)) - 1;
      build_model(ra, rs);
      if (rerr >= 0 && rerr < exp_addr_q.size()) exp_werr = 1'b1;
      run_req(ra, rs, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rerr, 0,
              n_aw, last_len);
      check($sformatf("rand%0d_werr", r), 64'(O_fdma_werr), 64'(exp_werr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fdma_axi_wmaster.md
# fdma_axi_wmaster

FDMA write master: converts single FDMA write requests (address, beat count) from the per-channel write buffer stage into AXI4 INCR write bursts on the shared DDR AXI port. Sits directly downstream of the channel write block. It consumes `fdma_waddr`/`fdma_wareq`/`fdma_wsize`, reports `fdma_wbusy`, and pops that block's data FIFO through `fdma_wvalid`. Bursts are split at the maximum AXI length and at every 4 KB boundary.

## Interface
- AXI_DATA_WIDTH, 128, data bus width in bits (power of 2, 32..512)
- AXI_ADDR_WIDTH, 32, address width
- AXI_MAX_BURST_LEN, 256, maximum beats per AXI burst (1..256)
- AXI_ID, 0, constant AWID value (4-bit)

Ports:
- I_ui_clk, in, 1, single clock for all logic
- I_ui_rst, in, 1, synchronous, active-high reset
- I_fdma_waddr, in, AXI_ADDR_WIDTH, byte start address; low log2(AXI_DATA_WIDTH/8) bits are ignored
- I_fdma_wareq, in, 1, request strobe, sampled only in IDLE
- I_fdma_wsize, in, 16, total beats for the request
- O_fdma_wbusy, out, 1, request in progress
- O_fdma_wvalid, out, 1, pop strobe for the data FIFO; one beat consumed per high cycle
- I_fdma_wdata, in, AXI_DATA_WIDTH, show-ahead FIFO data, valid in the same cycle as O_fdma_wvalid
- O_fdma_werr, out, 1, sticky flag for BRESP != OKAY; cleared by reset only
- M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID, out, 4/AXI_ADDR_WIDTH/8/3/2/1, AW channel
- M_AXI_AWREADY, in, 1
- M_AXI_WDATA/WSTRB/WLAST/WVALID, out, AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1, W channel
- M_AXI_WREADY, in, 1
- M_AXI_BRESP, in, 2; M_AXI_BVALID, in, 1; M_AXI_BREADY, out, 1

## Operation
- States: IDLE, AW, W, B.
- **IDLE**
  - When I_fdma_wareq=1 and wsize≠0: latch addr (beat-aligned), remaining=wsize, set busy, go to AW.
  - When wsize=0: busy=1 for exactly one cycle, no AXI traffic.
- **AW**
  - len = min(remaining, AXI_MAX_BURST_LEN, (4096 − addr[11:0]) / BPB), where BPB = AXI_DATA_WIDTH/8.
  - Drive AWADDR=addr, AWLEN=len−1, AWSIZE=log2(BPB), AWBURST=INCR (01), AWID=AXI_ID.
  - Hold AWVALID until AWREADY, then go to W.
- **W**
  - WVALID=1 continuously. WDATA=I_fdma_wdata. WSTRB all ones.
  - O_fdma_wvalid = WVALID & WREADY (combinational).
  - WLAST is high on beat len of the burst. The handshake on WLAST goes to B.
- **B**
  - BREADY=1. On BVALID: set werr if BRESP≠00; addr += len·BPB; remaining −= len.
  - If remaining=0: go to IDLE and drop busy. Otherwise go to AW.
- Exactly one burst is outstanding at a time. AW and W never overlap.
- The upstream stage guarantees the FIFO holds ≥wsize beats before asserting wareq. No underflow check is made.
- wareq while busy is ignored. The request is not queued.
- Address arithmetic is modulo 2^AXI_ADDR_WIDTH. No error on wrap.

## Timing
- Reset values: busy=0, wvalid=0, werr=0, AWVALID=0, WVALID=0, WLAST=0, BREADY=0, AWADDR=0, AWLEN=0. AWSIZE and AWBURST are constant.
- wareq sampled high in IDLE at cycle n: busy=1 and AWVALID=1 at n+1. All AW fields are registered and stable while AWVALID=1.
- AW handshake at cycle m: WVALID=1 at m+1.
- Last B handshake at cycle k: busy=0 at k+1, IDLE at k+1. A new wareq is accepted at k+1.
- Reset mid-operation: next cycle is IDLE with all valids low. The AXI protocol break is accepted because the reset is system-wide.
- WREADY low stalls: WDATA, WLAST and the beat counter hold, and wvalid=0.

## Structure
- Package `fdma_axi_pkg`: AXI_BURST_INCR, AXI_RESP_OKAY, the 4 KB boundary constant, and a clog2 function.
- Sub-module `fdma_burst_calc`: purely combinational len computation from (addr[11:0], remaining). It is instantiated once and unit-tested separately.
- Top holds the FSM, beat counter, address and remaining registers.

## Test plan
- **Single burst:** addr 0x0000_0000, wsize 240 (1920×32b / 128b / 2) with WREADY always 1 → one AW with AWLEN=239; 240 pops; WLAST on beat 240; busy drops one cycle after B.
- **Length split:** addr 0x0, wsize 600 → the 4 KB boundary applies first (BPB=16 gives 256 beats per 4 KB) → AWLEN sequence 255, 255, 87 at addrs 0x0, 0x1000, 0x2000.
- **4 KB cross:** addr 0x0000_0F80, wsize 20 → bursts of 8 beats (AWLEN=7) at 0xF80, then 12 beats (AWLEN=11) at 0x1000.
- **Backpressure:** wsize 16 with WREADY toggling 1,0 and AWREADY delayed 5 cycles → exactly 16 pops, data order preserved, no pop while WREADY=0.
- **Error and zero size:** BRESP=SLVERR on the 2nd of 3 bursts → werr=1 and stays set, transfer completes. wsize=0 → busy high for exactly 1 cycle, no AWVALID.
- **Reset mid-W:** assert I_ui_rst during beat 5 of 240 → IDLE, all outputs at reset values next cycle; a new request afterwards completes normally.
